pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory line port (cacheline adapter side) between two requesters: the instruction side (prefetch unit read stream) and the data side (D-cache read/writeback).
- Moves whole 256-bit lines only. Grants one requester at a time and latches its request. Drives the memory port and routes the response back to the granted requester only.
- Data side has priority. A starvation counter guarantees forward progress for instruction fetch.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while inst_read is pending; when reached, the next arbitration goes to the instruction side.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inst_read  in  1  instruction line read request (prefetch pf_read)
- inst_address  in  32  instruction line address (prefetch pf_address)
- inst_resp  out  1  instruction read complete, single-cycle pulse
- inst_rdata  out  256  instruction line data, valid with inst_resp
- data_read  in  1  data line read request
- data_write  in  1  data line write request
- data_address  in  32  data line address
- data_wdata  in  256  data line write data
- data_resp  out  1  data transaction complete, single-cycle pulse
- data_rdata  out  256  data line read data, valid with data_resp on reads
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  32  memory line address
- pmem_wdata  out  256  memory write line
- pmem_resp  in  1  memory transaction complete
- pmem_rdata  in  256  memory read line

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE, starvation counter=0, latched address/wdata/write flag=0.
  - Outputs: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, inst_resp=0, data_resp=0, inst_rdata=0, data_rdata=0.
- States: IDLE, SERVE_INST, SERVE_DATA.
- IDLE arbitration (evaluated on the same cycle's inputs):
  - data_req = data_read | data_write.
  - Only one requester active: it wins.
  - Both active: data wins, unless counter >= STARVE_LIMIT, in which case inst wins.
  - Neither active: stay in IDLE.
- On grant (edge leaving IDLE):
  - Latch the winner's address. For data: also latch data_wdata and the write flag (write = data_write).
  - If data_read and data_write are both high, the request is treated as a write; this input combination is illegal but defined.
- SERVE_x:
  - pmem_address and pmem_wdata are driven from the latched registers; requester inputs are ignored after grant.
  - pmem_read = 1 for inst, or for data when the latched write flag is 0. pmem_write = latched write flag. Both are held until pmem_resp.
- Completion:
  - The cycle pmem_resp=1 in SERVE_x: x_resp=1 and x_rdata=pmem_rdata, combinational same cycle; next state=IDLE.
  - pmem_read/write deassert on the following cycle.
  - The non-granted resp is always 0 and its rdata is 0.
- Gaps and latency:
  - Minimum one IDLE cycle between transactions; no back-to-back grant on the completion cycle.
  - Grant latency: 1 cycle from request in IDLE to pmem strobe.
- Starvation counter:
  - On data grant with inst_read=1: increment, saturating at 2^CNT_W-1.
  - On inst grant: clear to 0.
  - On data grant with inst_read=0: clear to 0.
- pmem_resp outside SERVE_x is ignored; no resp is generated.
- A requester dropping its request before its resp is illegal. The arbiter still completes the latched transaction and pulses resp.
- Reset mid-transaction: abort immediately. Strobes are 0 the cycle after the reset edge and no resp is issued for the aborted transaction.
- Requesters hold their request until their resp. The requester whose resp pulses in cycle N may deassert in cycle N+1. If a requester is still asserted in IDLE, it is treated as a new request.

Test Plan:
- Inst only: inst_read=1, inst_address=0x0000_0100; pmem_resp on cycle 4 with rdata=0xAA..AA -> pmem_read=1 with address 0x100 cycles 1-4; inst_resp=1 with inst_rdata=0xAA..AA in cycle 4; data_resp=0 throughout.
- Data write: data_write=1, address 0x8000_0020, wdata=0x1234..; pmem_resp after 3 cycles -> pmem_write=1, pmem_read=0, wdata matches; data_resp pulses 1 cycle.
- Simultaneous: inst_read and data_read both high at counter=0 -> data is served first; after data_resp and one IDLE cycle, inst is granted with its original address.
- Starvation: data_read held continuously, inst_read=1 -> exactly 4 data grants, then the 5th grant goes to inst (counter=4); counter returns to 0 afterwards.
- Address stability: change data_address from 0x40 to 0x80 mid-SERVE_DATA -> pmem_address stays 0x40 until resp.
- Reset mid-op: assert rst during SERVE_INST before pmem_resp -> next cycle pmem_read=0, state=IDLE, no inst_resp; a later pmem_resp pulse is ignored.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two line requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface pmem_arbiter_if;
  // instruction side (prefetch read stream)
  logic         inst_read;
  logic [31:0]  inst_address;
  logic         inst_resp;
  logic [255:0] inst_rdata;

  // data side (D-cache read / writeback)
  logic         data_read;
  logic         data_write;
  logic [31:0]  data_address;
  logic [255:0] data_wdata;
  logic         data_resp;
  logic [255:0] data_rdata;

  // physical memory line port
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport slave (
    input  inst_read, inst_address,
    input  data_read, data_write, data_address, data_wdata,
    input  pmem_resp, pmem_rdata,
    output inst_resp, inst_rdata,
    output data_resp, data_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output inst_read, inst_address,
    output data_read, data_write, data_address, data_wdata,
    output pmem_resp, pmem_rdata,
    input  inst_resp, inst_rdata,
    input  data_resp, data_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter for the 256-bit physical-memory line port.
// Data side has priority; a saturating starvation counter forces an
// instruction grant after STARVE_LIMIT consecutive data grants made while
// an instruction read was waiting.
module pmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_INST = 2'd1,
    SERVE_DATA = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if ((64'd1 << CNT_W) <= 64'(STARVE_LIMIT)) begin : g_bad_cnt_w
      $error("pmem_arbiter: CNT_W too narrow to hold STARVE_LIMIT");
    end
  endgenerate

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           wr_q, wr_d;

  logic data_req;
  logic starved;

  // Arbitration in IDLE, request latching on grant, return to IDLE on pmem_resp.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    data_req = bus.data_read | bus.data_write;
    starved  = (cnt_q >= LIMIT);

    unique case (state_q)
      IDLE: begin
        // Data wins unless an instruction read is waiting and has been starved.
        if (data_req && !(bus.inst_read && starved)) begin
          state_d = SERVE_DATA;
          addr_d  = bus.data_address;
          wdata_d = bus.data_wdata;
          // read+write together resolves to a write
          wr_d    = bus.data_write;
          if (bus.inst_read) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
          end
        end else if (bus.inst_read) begin
          state_d = SERVE_INST;
          addr_d  = bus.inst_address;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      SERVE_INST: begin
        if (bus.pmem_resp) state_d = IDLE;
      end
      SERVE_DATA: begin
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes from latched state; responses routed only to the granted side.
  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.inst_resp    = 1'b0;
    bus.inst_rdata   = '0;
    bus.data_resp    = 1'b0;
    bus.data_rdata   = '0;

    unique case (state_q)
      SERVE_INST: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.inst_resp  = 1'b1;
          bus.inst_rdata = bus.pmem_rdata;
        end
      end
      SERVE_DATA: begin
        bus.pmem_read  = ~wr_q;
        bus.pmem_write = wr_q;
        if (bus.pmem_resp) begin
          bus.data_resp  = 1'b1;
          bus.data_rdata = bus.pmem_rdata;
        end
      end
      default: ;
    endcase
  end

  // State and latched-request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a resp pulse appears.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_arbiter_if bus ();

  pmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // expected response: {side (0=inst,1=data), rdata}
  logic [256:0] exp_q[$];

  localparam logic [255:0] AA = {32{8'hAA}};
  localparam logic [255:0] W1 = {8{32'h1234_5678}};
  localparam logic [255:0] W2 = {8{32'hCAFE_F00D}};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every response pulse against the scoreboard.
  initial begin
    logic [256:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.inst_resp && bus.data_resp) chk("resp_exclusive", 256'd1, 256'd0);
        if (bus.inst_resp || bus.data_resp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", {254'd0, bus.data_resp, bus.inst_resp}, 256'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_side", {255'd0, bus.data_resp}, {255'd0, e[256]});
            if (e[256]) begin
              chk("data_rdata", bus.data_rdata, e[255:0]);
              chk("inst_rdata_idle", bus.inst_rdata, '0);
            end else begin
              chk("inst_rdata", bus.inst_rdata, e[255:0]);
              chk("data_rdata_idle", bus.data_rdata, '0);
            end
          end
        end else begin
          chk("rdata_quiet", bus.inst_rdata | bus.data_rdata, '0);
        end
      end
    end
  end

  // Memory-side responder: wait for a strobe, check it, hold for lat cycles, respond.
  task automatic serve(input bit side, input bit exp_wr, input logic [31:0] exp_addr,
                       input logic [255:0] exp_wd, input int unsigned lat,
                       input logic [255:0] rdata, input int unsigned exp_wait,
                       input bit mid_change);
    int unsigned waited = 0;
    bit found = 1'b0;
    while (!found && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      if (bus.pmem_read || bus.pmem_write) found = 1'b1;
    end
    if (!found) begin
      chk("grant_timeout", 256'd0, 256'd1);
      return;
    end
    chk("grant_latency", 256'(waited), 256'(exp_wait));
    chk("pmem_read", {255'd0, bus.pmem_read}, {255'd0, ~exp_wr});
    chk("pmem_write", {255'd0, bus.pmem_write}, {255'd0, exp_wr});
    chk("pmem_address", 256'(bus.pmem_address), 256'(exp_addr));
    if (exp_wr) chk("pmem_wdata", bus.pmem_wdata, exp_wd);
    for (int unsigned i = 1; i < lat; i++) begin
      if (mid_change && i == 1) bus.data_address = 32'h0000_0080;
      @(posedge clk); #1;
      chk("strobe_held", {254'd0, bus.pmem_read, bus.pmem_write}, {254'd0, ~exp_wr, exp_wr});
      chk("address_held", 256'(bus.pmem_address), 256'(exp_addr));
    end
    exp_q.push_back({side, rdata});
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rdata;
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    chk("strobe_drop", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd0);
  endtask

  initial begin
    bus.inst_read    = 1'b0;
    bus.inst_address = '0;
    bus.data_read    = 1'b0;
    bus.data_write   = 1'b0;
    bus.data_address = '0;
    bus.data_wdata   = '0;
    bus.pmem_resp    = 1'b0;
    bus.pmem_rdata   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_pmem_read", {255'd0, bus.pmem_read}, 256'd0);
    chk("rst_pmem_write", {255'd0, bus.pmem_write}, 256'd0);
    chk("rst_pmem_address", 256'(bus.pmem_address), 256'd0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_inst_resp", {255'd0, bus.inst_resp}, 256'd0);
    chk("rst_data_resp", {255'd0, bus.data_resp}, 256'd0);
    chk("rst_inst_rdata", bus.inst_rdata, '0);
    chk("rst_data_rdata", bus.data_rdata, '0);
    mon_en = 1'b1;

    // instruction read only, memory answers in the 4th strobe cycle
    bus.inst_read = 1'b1; bus.inst_address = 32'h0000_0100;
    serve(1'b0, 1'b0, 32'h0000_0100, '0, 4, AA, 1, 1'b0);
    bus.inst_read = 1'b0;

    // data write
    bus.data_write = 1'b1; bus.data_address = 32'h8000_0020; bus.data_wdata = W1;
    serve(1'b1, 1'b1, 32'h8000_0020, W1, 3, {8{32'hDEAD_BEEF}}, 1, 1'b0);
    bus.data_write = 1'b0;

    // simultaneous: data first, then inst after one IDLE cycle
    bus.inst_read = 1'b1; bus.inst_address = 32'h0000_0200;
    bus.data_read = 1'b1; bus.data_address = 32'h0000_0300;
    serve(1'b1, 1'b0, 32'h0000_0300, '0, 2, {8{32'h0000_3333}}, 1, 1'b0);
    bus.data_read = 1'b0;
    serve(1'b0, 1'b0, 32'h0000_0200, '0, 2, {8{32'h0000_2222}}, 1, 1'b0);
    bus.inst_read = 1'b0;

    // starvation, two rounds: the second proves the counter was cleared
    bus.inst_read = 1'b1; bus.inst_address = 32'h0000_0400;
    bus.data_read = 1'b1; bus.data_address = 32'h0000_0500;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        serve(1'b1, 1'b0, 32'h0000_0500, '0, 1, 256'(k + 16 * r + 1), 1, 1'b0);
      serve(1'b0, 1'b0, 32'h0000_0400, '0, 1, 256'(32'h100 + r), 1, 1'b0);
    end
    bus.inst_read = 1'b0;
    bus.data_read = 1'b0;

    // read and write together resolve to a write
    bus.data_read = 1'b1; bus.data_write = 1'b1;
    bus.data_address = 32'h0000_0600; bus.data_wdata = W2;
    serve(1'b1, 1'b1, 32'h0000_0600, W2, 2, {8{32'h0000_6666}}, 1, 1'b0);
    bus.data_read = 1'b0; bus.data_write = 1'b0;

    // address stability while serving
    bus.data_read = 1'b1; bus.data_address = 32'h0000_0040;
    serve(1'b1, 1'b0, 32'h0000_0040, '0, 3, {8{32'h0000_4040}}, 1, 1'b1);
    bus.data_read = 1'b0;

    // reset mid-transaction, then a stray pmem_resp in IDLE
    bus.inst_read = 1'b1; bus.inst_address = 32'h0000_0700;
    @(posedge clk); #1;
    chk("abort_pre_strobe", {255'd0, bus.pmem_read}, 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.inst_read = 1'b0;
    chk("abort_strobes", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd0);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = AA;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    chk("stray_resp_strobes", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
